// File: rtl/lcd_write_arbiter_pkg.sv
// Shared definitions for the character-LCD write arbiter: FSM state
// encodings, LCD command constants and the clear/home detection helper.
package lcd_write_arbiter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HI_SETUP = 4'd1,
        ST_HI_PULSE = 4'd2,
        ST_HI_HOLD  = 4'd3,
        ST_GAP      = 4'd4,
        ST_LO_SETUP = 4'd5,
        ST_LO_PULSE = 4'd6,
        ST_LO_HOLD  = 4'd7,
        ST_WAIT     = 4'd8
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Clear and home are the two commands the LCD needs a long settle time for.
    function automatic logic is_clear_home(input logic rs, input logic [7:0] cmd);
        return (rs == 1'b0) && ((cmd == LCD_CMD_CLEAR) || (cmd == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_write_arbiter_phase_timer.sv
// Loadable down-counter that times each FSM phase. Loading N makes done
// rise after exactly N cycles (done while count == 1).
module lcd_phase_timer #(
    parameter int CNT_W = 17
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Reload on phase entry, otherwise count down and park at zero.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= value;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/lcd_write_arbiter.sv
// Two-port fixed-priority arbiter for the 4-bit character-LCD bus. Port 0
// (init sequencer) beats port 1 (ALU write path). Each accepted byte is
// sent as high then low nibble with timed E pulses, followed by a settle
// wait. Optional macro LCD_CLEAR_LONG_WAIT_EN selects a long settle time
// for the clear and home commands.
module lcd_write_arbiter
    import lcd_write_arbiter_pkg::*;
#(
    parameter int SETUP_CYC      = 2,
    parameter int PULSE_CYC      = 12,
    parameter int HOLD_CYC       = 1,
    parameter int GAP_CYC        = 50,
    parameter int BYTE_WAIT_CYC  = 2000,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int CNT_W          = 17
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iReq0_Valid,
    input  logic       iReq0_RS,
    input  logic [7:0] iReq0_Data,
    output logic       oReq0_Ready,
    input  logic       iReq1_Valid,
    input  logic       iReq1_RS,
    input  logic [7:0] iReq1_Data,
    output logic       oReq1_Ready,
    output logic       oBusy,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_StrataFlashControl,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data
);

`ifdef LCD_CLEAR_LONG_WAIT_EN
    localparam bit LONG_WAIT_EN = 1'b1;
`else
    localparam bit LONG_WAIT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] SETUP_VAL_C = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] PULSE_VAL_C = CNT_W'(PULSE_CYC);
    localparam logic [CNT_W-1:0] HOLD_VAL_C  = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] GAP_VAL_C   = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] BYTE_VAL_C  = CNT_W'(BYTE_WAIT_CYC);
    localparam logic [CNT_W-1:0] CLEAR_VAL_C = CNT_W'(CLEAR_WAIT_CYC);

    lcd_state_e       state_r, state_nxt_s;
    logic [7:0]       byte_r, byte_nxt_s;
    logic             rs_r, rs_nxt_s;
    logic             e_r, e_nxt_s;
    logic             lcd_rs_r, lcd_rs_nxt_s;
    logic [3:0]       lcd_data_r, lcd_data_nxt_s;
    logic             idle_s, accept0_s, accept1_s, accept_s;
    logic             load_s, done_s;
    logic [CNT_W-1:0] load_val_s, wait_val_s;

    assign idle_s      = (state_r == ST_IDLE);
    assign oReq0_Ready = idle_s;
    assign oReq1_Ready = idle_s & ~iReq0_Valid & ~Reset;
    assign accept0_s   = iReq0_Valid & oReq0_Ready;
    assign accept1_s   = iReq1_Valid & oReq1_Ready;
    assign accept_s    = accept0_s | accept1_s;

    // The byte being captured this cycle, so outputs can follow it at once.
    assign byte_nxt_s = accept0_s ? iReq0_Data : (accept1_s ? iReq1_Data : byte_r);
    assign rs_nxt_s   = accept0_s ? iReq0_RS   : (accept1_s ? iReq1_RS   : rs_r);

    // Settle time depends on the latched byte only; the feature flag is constant.
    assign wait_val_s = (LONG_WAIT_EN && is_clear_home(rs_r, byte_r)) ? CLEAR_VAL_C : BYTE_VAL_C;

    lcd_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .Clock (Clock),
        .Reset (Reset),
        .load  (load_s),
        .value (load_val_s),
        .done  (done_s)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: leave IDLE on an accept, leave other phases when the timer expires.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:     state_nxt_s = accept_s ? ST_HI_SETUP : ST_IDLE;
            ST_HI_SETUP: state_nxt_s = done_s ? ST_HI_PULSE : ST_HI_SETUP;
            ST_HI_PULSE: state_nxt_s = done_s ? ST_HI_HOLD  : ST_HI_PULSE;
            ST_HI_HOLD:  state_nxt_s = done_s ? ST_GAP      : ST_HI_HOLD;
            ST_GAP:      state_nxt_s = done_s ? ST_LO_SETUP : ST_GAP;
            ST_LO_SETUP: state_nxt_s = done_s ? ST_LO_PULSE : ST_LO_SETUP;
            ST_LO_PULSE: state_nxt_s = done_s ? ST_LO_HOLD  : ST_LO_PULSE;
            ST_LO_HOLD:  state_nxt_s = done_s ? ST_WAIT     : ST_LO_HOLD;
            ST_WAIT:     state_nxt_s = done_s ? ST_IDLE     : ST_WAIT;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs for the coming state: timer reload on phase entry and the pin values.
    always_comb begin
        load_s         = 1'b0;
        load_val_s     = {CNT_W{1'b0}};
        e_nxt_s        = 1'b0;
        lcd_rs_nxt_s   = lcd_rs_r;
        lcd_data_nxt_s = lcd_data_r;
        if ((state_nxt_s != state_r) && (state_nxt_s != ST_IDLE)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        case (state_nxt_s)
            ST_HI_SETUP, ST_LO_SETUP: load_val_s = SETUP_VAL_C;
            ST_HI_PULSE, ST_LO_PULSE: load_val_s = PULSE_VAL_C;
            ST_HI_HOLD,  ST_LO_HOLD:  load_val_s = HOLD_VAL_C;
            ST_GAP:                   load_val_s = GAP_VAL_C;
            ST_WAIT:                  load_val_s = wait_val_s;
            default:                  load_val_s = {CNT_W{1'b0}};
        endcase
        case (state_nxt_s)
            ST_HI_SETUP, ST_HI_PULSE, ST_HI_HOLD, ST_GAP: begin
                lcd_data_nxt_s = byte_nxt_s[7:4];
                lcd_rs_nxt_s   = rs_nxt_s;
            end
            ST_LO_SETUP, ST_LO_PULSE, ST_LO_HOLD, ST_WAIT: begin
                lcd_data_nxt_s = byte_nxt_s[3:0];
                lcd_rs_nxt_s   = rs_nxt_s;
            end
            default: begin
                lcd_data_nxt_s = lcd_data_r;
                lcd_rs_nxt_s   = lcd_rs_r;
            end
        endcase
        if ((state_nxt_s == ST_HI_PULSE) || (state_nxt_s == ST_LO_PULSE)) begin
            e_nxt_s = 1'b1;
        end else begin
            e_nxt_s = 1'b0;
        end
    end

    // Latched request and registered LCD pins.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            byte_r     <= 8'h00;
            rs_r       <= 1'b0;
            e_r        <= 1'b0;
            lcd_rs_r   <= 1'b0;
            lcd_data_r <= 4'h0;
        end else begin
            byte_r     <= byte_nxt_s;
            rs_r       <= rs_nxt_s;
            e_r        <= e_nxt_s;
            lcd_rs_r   <= lcd_rs_nxt_s;
            lcd_data_r <= lcd_data_nxt_s;
        end
    end

    assign oBusy                   = ~idle_s;
    assign oLCD_Enabled            = e_r;
    assign oLCD_RegisterSelect     = lcd_rs_r;
    assign oLCD_Data               = lcd_data_r;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_ReadWrite          = 1'b0;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Self-checking bench for lcd_write_arbiter: nibble scoreboard driven by an
// E-pulse monitor, a table of single-byte writes with expected occupancy,
// and hand-written sequences for contention, mid-pulse reset and streaming.
module tb_lcd_write_arbiter;

    localparam int PULSE = 12;
    localparam int T_STD = 2080;
`ifdef LCD_CLEAR_LONG_WAIT_EN
    localparam int T_CLR = 82080;
`else
    localparam int T_CLR = 2080;
`endif
    localparam int BOUND = 100000;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iReq0_Valid, iReq0_RS, iReq1_Valid, iReq1_RS;
    logic [7:0] iReq0_Data, iReq1_Data;
    logic       oReq0_Ready, oReq1_Ready, oBusy;
    logic       oLCD_Enabled, oLCD_RegisterSelect, oLCD_StrataFlashControl, oLCD_ReadWrite;
    logic [3:0] oLCD_Data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulse_count = 0;
    int width = 0;
    logic prev_e = 1'b0;
    logic [4:0] sb_q[$];
    int rise_q[$];

    typedef struct {
        int         port;
        logic       rs;
        logic [7:0] data;
        int         exp_t;
    } vec_t;
    vec_t vecs[4];

    lcd_write_arbiter dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .iReq0_Valid             (iReq0_Valid),
        .iReq0_RS                (iReq0_RS),
        .iReq0_Data              (iReq0_Data),
        .oReq0_Ready             (oReq0_Ready),
        .iReq1_Valid             (iReq1_Valid),
        .iReq1_RS                (iReq1_RS),
        .iReq1_Data              (iReq1_Data),
        .oReq1_Ready             (oReq1_Ready),
        .oBusy                   (oBusy),
        .oLCD_Enabled            (oLCD_Enabled),
        .oLCD_RegisterSelect     (oLCD_RegisterSelect),
        .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
        .oLCD_ReadWrite          (oLCD_ReadWrite),
        .oLCD_Data               (oLCD_Data)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // E-pulse monitor: each rising edge pops one expected {RS,nibble}; each pulse width is checked.
    always @(negedge Clock) begin
        if (oLCD_Enabled && !prev_e) begin
            rise_q.push_back(cyc);
            pulse_count++;
            width = 1;
            if (sb_q.size() == 0) begin
                check("unexpected E pulse", 32'd1, 32'd0);
            end else begin
                check("nibble {RS,Data}", {27'd0, oLCD_RegisterSelect, oLCD_Data}, {27'd0, sb_q.pop_front()});
            end
        end else if (oLCD_Enabled) begin
            width++;
        end else if (prev_e && !Reset) begin
            check("E pulse width", width, PULSE);
        end
        prev_e = oLCD_Enabled;
    end

    task automatic push_byte(input logic rs, input logic [7:0] d);
        sb_q.push_back({rs, d[7:4]});
        sb_q.push_back({rs, d[3:0]});
    endtask

    task automatic drive(input int port, input logic rs, input logic [7:0] d);
        if (port == 0) begin
            iReq0_Valid = 1'b1; iReq0_RS = rs; iReq0_Data = d;
        end else begin
            iReq1_Valid = 1'b1; iReq1_RS = rs; iReq1_Data = d;
        end
    endtask

    // Call at a falling edge; returns just after the falling edge preceding the accepting edge.
    task automatic wait_hs(input int port);
        bit ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            #1;
            if ((port == 0 && iReq0_Valid && oReq0_Ready) || (port == 1 && iReq1_Valid && oReq1_Ready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clock);
        end
        if (!ok) check("handshake timeout", 32'd0, 32'd1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge Clock); #1;
            if (oBusy) n++;
            else break;
        end
    endtask

    initial begin
        int n;
        int pc;
        int idx;
        Reset = 1'b1;
        iReq0_Valid = 1'b0; iReq0_RS = 1'b0; iReq0_Data = 8'h00;
        iReq1_Valid = 1'b0; iReq1_RS = 1'b0; iReq1_Data = 8'h00;

        vecs[0] = '{port: 0, rs: 1'b0, data: 8'h01, exp_t: T_CLR};
        vecs[1] = '{port: 0, rs: 1'b1, data: 8'h01, exp_t: T_STD};
        vecs[2] = '{port: 1, rs: 1'b1, data: 8'h02, exp_t: T_STD};
        vecs[3] = '{port: 1, rs: 1'b0, data: 8'hC7, exp_t: T_STD};

        // Reset state while Reset is high.
        repeat (3) @(negedge Clock);
        check("reset E", oLCD_Enabled, 1'b0);
        check("reset RS", oLCD_RegisterSelect, 1'b0);
        check("reset Data", oLCD_Data, 4'h0);
        check("reset SF", oLCD_StrataFlashControl, 1'b1);
        check("reset RW", oLCD_ReadWrite, 1'b0);
        check("reset Busy", oBusy, 1'b0);
        check("reset Ready0", oReq0_Ready, 1'b1);
        check("reset Ready1", oReq1_Ready, 1'b0);
        Reset = 1'b0;
        @(negedge Clock);

        // Single write on port 1: Ready1 low for exactly T cycles.
        drive(1, 1'b1, 8'h41);
        wait_hs(1);
        push_byte(1'b1, 8'h41);
        @(posedge Clock); #1; iReq1_Valid = 1'b0;
        n = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge Clock); #1;
            if (!oReq1_Ready) n++;
            else break;
        end
        check("single write Ready1 low cycles", n, T_STD);

        // Table of single-byte writes with expected occupancy.
        for (int v = 0; v < 4; v++) begin
            @(negedge Clock);
            drive(vecs[v].port, vecs[v].rs, vecs[v].data);
            wait_hs(vecs[v].port);
            push_byte(vecs[v].rs, vecs[v].data);
            @(posedge Clock); #1;
            iReq0_Valid = 1'b0; iReq1_Valid = 1'b0;
            count_busy(n);
            check($sformatf("occupancy vec%0d", v), n, vecs[v].exp_t);
        end

        // Contention: port 0 wins, port 1 is served once the arbiter is idle again.
        @(negedge Clock);
        drive(0, 1'b0, 8'h28);
        drive(1, 1'b1, 8'h48);
        push_byte(1'b0, 8'h28);
        push_byte(1'b1, 8'h48);
        wait_hs(0);
        check("contention Ready1 while port0 valid", oReq1_Ready, 1'b0);
        @(posedge Clock); #1; iReq0_Valid = 1'b0;
        n = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge Clock); #1;
            n++;
            if (oReq1_Ready) break;
        end
        check("contention Ready1 first high", n, T_STD + 1);
        @(posedge Clock); #1; iReq1_Valid = 1'b0;
        count_busy(n);
        check("contention port1 occupancy", n, T_STD);

        // Reset during the 5th cycle of the high-nibble pulse.
        @(negedge Clock);
        drive(1, 1'b1, 8'h5A);
        wait_hs(1);
        push_byte(1'b1, 8'h5A);
        @(posedge Clock); #1; iReq1_Valid = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge Clock); #1;
            if (oLCD_Enabled) break;
        end
        repeat (4) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock); #1;
        check("mid-pulse reset E", oLCD_Enabled, 1'b0);
        check("mid-pulse reset Busy", oBusy, 1'b0);
        check("mid-pulse reset Data", oLCD_Data, 4'h0);
        Reset = 1'b0;
        sb_q.delete();
        pc = pulse_count;
        repeat (30) @(negedge Clock);
        check("no pulse after reset", pulse_count, pc);
        drive(1, 1'b0, 8'h33);
        wait_hs(1);
        push_byte(1'b0, 8'h33);
        @(posedge Clock); #1; iReq1_Valid = 1'b0;
        count_busy(n);
        check("post-reset occupancy", n, T_STD);
        check("post-reset pulses", pulse_count, pc + 2);

        // Streaming: port 1 holds Valid for three bytes.
        @(negedge Clock);
        pc = pulse_count;
        idx = rise_q.size();
        drive(1, 1'b1, 8'h61);
        for (int b = 0; b < 3; b++) begin
            wait_hs(1);
            push_byte(1'b1, iReq1_Data);
            @(posedge Clock); #1;
            if (b < 2) iReq1_Data = iReq1_Data + 8'h01;
            else iReq1_Valid = 1'b0;
            @(negedge Clock);
        end
        count_busy(n);
        repeat (5) @(negedge Clock);
        check("streaming pulse count", pulse_count, pc + 6);
        if (rise_q.size() >= idx + 5) begin
            check("streaming spacing 1-2", rise_q[idx + 2] - rise_q[idx], T_STD + 1);
            check("streaming spacing 2-3", rise_q[idx + 4] - rise_q[idx + 2], T_STD + 1);
        end else begin
            check("streaming rise records", rise_q.size(), idx + 6);
        end

        check("scoreboard drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
